// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1-style framing, optional second stop bit) feeding a small receive FIFO.
// Define UART_RX_PARITY_EN to add the even/odd parity bit check and the io_parity_err pulse.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              io_div,
    input  logic                          io_en,
    input  logic [1:0]                    io_parity,
    input  logic                          io_stop2,
    input  logic                          io_rxd,
    output logic                          io_deq_valid,
    input  logic                          io_deq_ready,
    output logic [DATA_BITS-1:0]          io_deq_bits,
    output logic [$clog2(FIFO_DEPTH):0]   io_count,
    output logic                          io_frame_err,
    output logic                          io_parity_err,
    output logic                          io_overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP1, STOP2} state_t;
`endif

    state_t               state, state_n;
    logic                 sync1, sync2, line;
    logic [DIV_W-1:0]     cnt, cnt_n;
    logic [DIV_W-1:0]     div_q, div_n;
    logic                 stop2_q, stop2_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic                 tick;
    logic                 push;
    logic                 frame_err_q, frame_err_n;
    logic                 overrun_q;

`ifdef UART_RX_PARITY_EN
    logic [1:0]           par_q, par_n;
    logic                 par_pend, par_pend_n;
    logic                 parity_err_q, parity_err_n;
    logic                 par_on;
    logic                 par_exp;

    assign par_on  = (par_q == 2'b01) || (par_q == 2'b10);
    assign par_exp = (^shreg) ^ par_q[1];
`else
    logic                 unused_parity;

    assign unused_parity = ^io_parity;
`endif

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 pop, full, wr_ok;

    assign line = sync2;
    assign tick = (cnt == '0);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        div_n       = div_q;
        stop2_n     = stop2_q;
        shreg_n     = shreg;
        bit_idx_n   = bit_idx;
        push        = 1'b0;
        frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n        = par_q;
        par_pend_n   = par_pend;
        parity_err_n = 1'b0;
`endif
        if (state != IDLE) begin
            cnt_n = tick ? div_q : cnt - 1'b1;
        end

        case (state)
            IDLE: begin
                if (!line) begin
                    state_n   = START;
                    cnt_n     = io_div >> 1;
                    bit_idx_n = '0;
`ifdef UART_RX_PARITY_EN
                    par_pend_n = 1'b0;
`endif
                end
            end
            START: begin
                // Frame configuration is captured here so mid-frame changes cannot corrupt timing.
                if (tick) begin
                    cnt_n = io_div;
                    if (line) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        div_n   = io_div;
                        stop2_n = io_stop2;
`ifdef UART_RX_PARITY_EN
                        par_n   = io_parity;
`endif
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_n   = {line, shreg[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx + BW'(1);
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_n = par_on ? PARITY : STOP1;
`else
                        state_n = STOP1;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (line != par_exp) begin
                        par_pend_n = 1'b1;
                    end
                    state_n = STOP1;
                end
            end
`endif
            STOP1, STOP2: begin
                if (tick) begin
                    state_n = IDLE;
                    if (!line) begin
                        frame_err_n = 1'b1;
                    end else if (state == STOP1 && stop2_q) begin
                        state_n = STOP2;
                    end else begin
                        push = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_n = par_pend;
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Disable wins over everything, including a frame completing this cycle.
        if (!io_en) begin
            state_n     = IDLE;
            push        = 1'b0;
            frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            div_q       <= '0;
            stop2_q     <= 1'b0;
            shreg       <= '0;
            bit_idx     <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 2'b00;
            par_pend     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1       <= io_rxd;
            sync2       <= sync1;
            state       <= state_n;
            cnt         <= cnt_n;
            div_q       <= div_n;
            stop2_q     <= stop2_n;
            shreg       <= shreg_n;
            bit_idx     <= bit_idx_n;
            frame_err_q <= frame_err_n;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_n;
            par_pend     <= par_pend_n;
            parity_err_q <= parity_err_n;
`endif
        end
    end

    assign pop   = (count != '0) && io_deq_ready;
    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && full && !pop;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign io_deq_valid = (count != '0);
    assign io_deq_bits  = io_deq_valid ? mem[rd_ptr] : '0;
    assign io_count     = count;
    assign io_frame_err = frame_err_q;
    assign io_overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign io_parity_err = parity_err_q;
`else
    assign io_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of frames plus hand-written overrun, enable,
// false-start and mid-frame reset sequences. Parity expectations follow UART_RX_PARITY_EN.
module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int BIT_CLKS = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] io_div;
    logic        io_en;
    logic [1:0]  io_parity;
    logic        io_stop2;
    logic        io_rxd;
    logic        io_deq_valid;
    logic        io_deq_ready;
    logic [7:0]  io_deq_bits;
    logic [2:0]  io_count;
    logic        io_frame_err;
    logic        io_parity_err;
    logic        io_overrun;

    always #5 clock = ~clock;

    uart_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clock(clock), .reset(reset), .io_div(io_div), .io_en(io_en),
        .io_parity(io_parity), .io_stop2(io_stop2), .io_rxd(io_rxd),
        .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready),
        .io_deq_bits(io_deq_bits), .io_count(io_count),
        .io_frame_err(io_frame_err), .io_parity_err(io_parity_err),
        .io_overrun(io_overrun)
    );

    // Count high cycles of each pulse; a pulse longer than one cycle shows up as >1.
    int fe_n = 0, pe_n = 0, ov_n = 0;
    always @(negedge clock) begin
        if (io_frame_err)  fe_n++;
        if (io_parity_err) pe_n++;
        if (io_overrun)    ov_n++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b);
        io_rxd = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] par, input logic pb,
                              input logic s2, input logic last_stop);
        io_parity = par;
        io_stop2  = s2;
        send_bit(1'b0);
        for (int b = 0; b < 8; b++) send_bit(d[b]);
        if (PEN && (par == 2'b01 || par == 2'b10)) send_bit(pb);
        if (s2) send_bit(1'b1);
        send_bit(last_stop);
        io_rxd = 1'b1;
        repeat (12) @(negedge clock);
    endtask

    task automatic pop_one();
        io_deq_ready = 1'b1;
        @(negedge clock);
        io_deq_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] parity;
        logic       par_bit;
        logic       stop2;
        logic       last_stop;
        int         exp_push;
        int         exp_fe;
        int         exp_pe;   // only when parity support is built in
    } vec_t;

    vec_t vt[9];
    int   fe0, pe0, ov0;

    initial begin
        vt[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1, 0, 0};
        vt[1] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1, 0};
        vt[2] = '{8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 1, 0, 1};
        vt[3] = '{8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1, 0, 0};
        vt[4] = '{8'h0F, 2'b10, 1'b1, 1'b0, 1'b1, 1, 0, 0};
        vt[5] = '{8'h00, 2'b00, 1'b0, 1'b1, 1'b1, 1, 0, 0};
        vt[6] = '{8'hFF, 2'b00, 1'b0, 1'b1, 1'b0, 0, 1, 0};
        vt[7] = '{8'h80, 2'b11, 1'b1, 1'b0, 1'b1, 1, 0, 0};
        vt[8] = '{8'h01, 2'b10, 1'b1, 1'b0, 1'b1, 1, 0, 1};

        reset = 1'b1; io_div = 16'd15; io_en = 1'b1; io_parity = 2'b00;
        io_stop2 = 1'b0; io_rxd = 1'b1; io_deq_ready = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_count", io_count, 0);
        check("rst_valid", io_deq_valid, 0);
        check("rst_bits", io_deq_bits, 0);
        check("rst_flags", {io_frame_err, io_parity_err, io_overrun}, 0);

        for (int i = 0; i < 9; i++) begin
            fe0 = fe_n; pe0 = pe_n; ov0 = ov_n;
            send_frame(vt[i].data, vt[i].parity, vt[i].par_bit, vt[i].stop2, vt[i].last_stop);
            check($sformatf("v%0d_count", i), io_count, vt[i].exp_push);
            if (vt[i].exp_push != 0) begin
                check($sformatf("v%0d_bits", i), io_deq_bits, vt[i].data);
                pop_one();
            end
            check($sformatf("v%0d_fe", i), fe_n - fe0, vt[i].exp_fe);
            check($sformatf("v%0d_pe", i), pe_n - pe0, PEN ? vt[i].exp_pe : 0);
            check($sformatf("v%0d_ov", i), ov_n - ov0, 0);
            check($sformatf("v%0d_empty", i), io_deq_valid, 0);
        end

        // Overrun: five frames into a four-entry FIFO with no consumer.
        fe0 = fe_n; ov0 = ov_n;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b1);
            check($sformatf("ovr_count%0d", i), io_count, (i > 4) ? 4 : i);
            check($sformatf("ovr_pulse%0d", i), ov_n - ov0, (i > 4) ? 1 : 0);
        end
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovr_pop%0d", i), io_deq_bits, i);
            pop_one();
        end
        check("ovr_drained", io_deq_valid, 0);
        check("ovr_fe", fe_n - fe0, 0);

        // Disable mid-frame: partial frame discarded, queued entry still poppable.
        send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1);
        fe0 = fe_n; pe0 = pe_n; ov0 = ov_n;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        io_en = 1'b0;
        repeat (3) @(negedge clock);
        io_rxd = 1'b1;
        check("en_bits", io_deq_bits, 8'h5A);
        pop_one();
        repeat (200) @(negedge clock);
        io_en = 1'b1;
        repeat (20) @(negedge clock);
        check("en_count", io_count, 0);
        check("en_flags", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 0);

        // False start: line low for only four clocks.
        fe0 = fe_n; pe0 = pe_n; ov0 = ov_n;
        io_rxd = 1'b0;
        repeat (4) @(negedge clock);
        io_rxd = 1'b1;
        repeat (40) @(negedge clock);
        check("fs_count", io_count, 0);
        check("fs_flags", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 0);
        send_frame(8'hC3, 2'b00, 1'b0, 1'b0, 1'b1);
        check("fs_next_bits", io_deq_bits, 8'hC3);
        check("fs_next_count", io_count, 1);
        pop_one();

        // Reset in the DATA phase of 0x81 with two entries queued.
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1);
        check("rm_pre_count", io_count, 2);
        fe0 = fe_n; pe0 = pe_n; ov0 = ov_n;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        reset  = 1'b1;
        io_rxd = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rm_count", io_count, 0);
        check("rm_valid", io_deq_valid, 0);
        check("rm_bits", io_deq_bits, 0);
        repeat (200) @(negedge clock);
        check("rm_idle_count", io_count, 0);
        send_frame(8'h7E, 2'b00, 1'b0, 1'b0, 1'b1);
        check("rm_next_count", io_count, 1);
        check("rm_next_bits", io_deq_bits, 8'h7E);
        check("rm_flags", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, the number of data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, the receive FIFO entries (power of 2, at least 2).
REQ-003 SHALL have parameter DIV_W, default 16, the width of the bit-period divisor.
REQ-004 SHALL have port `clock`  in  1: the single clock; the block is synchronous to it.
REQ-005 SHALL have port `reset`  in  1: synchronous, active-high reset.
REQ-006 SHALL have port `io_div`  in  DIV_W: bit period in clocks, minus 1 (minimum legal value 3).
REQ-007 SHALL have port `io_en`  in  1: receiver enable.
REQ-008 SHALL have port `io_parity`  in  2: 00 = none, 01 = even, 10 = odd, 11 = none.
REQ-009 SHALL have port `io_stop2`  in  1: two stop bits are checked when this is 1.
REQ-010 SHALL have port `io_rxd`  in  1: asynchronous serial input, idle high.
REQ-011 SHALL have port `io_deq_valid`  out  1: the FIFO is not empty.
REQ-012 SHALL have port `io_deq_ready`  in  1: consumer accepts the head entry.
REQ-013 SHALL have port `io_deq_bits`  out  DATA_BITS: the head FIFO entry.
REQ-014 SHALL have port `io_count`  out  clog2(FIFO_DEPTH)+1: the FIFO occupancy.
REQ-015 SHALL have ports `io_frame_err`, `io_parity_err`, `io_overrun`  out  1 each: single-cycle error pulses.

Function
REQ-016 SHALL pass `io_rxd` through a 2-flop synchronizer; every reference to "line" below means the synchronizer output.
REQ-017 SHALL implement the FSM states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-018 In IDLE with `io_en`=1, a line value of 0 SHALL cause a move to START, with the bit counter loaded to `io_div`>>1.
REQ-019 The bit counter SHALL decrement once per clock; a sample SHALL be taken in the cycle the counter equals 0, and the counter SHALL then reload to `io_div`.
REQ-020 On the START sample: line=1 SHALL be treated as a false start, returning to IDLE with no flags; line=0 SHALL move to DATA.
REQ-021 DATA SHALL shift in DATA_BITS samples, LSB first, and then go to PARITY if parity is enabled, otherwise to STOP1.
REQ-022 The PARITY sample SHALL be compared against the even or odd parity of the data; a mismatch SHALL latch a pending parity error.
REQ-023 STOP1 SHALL go to STOP2 when `io_stop2`=1; otherwise, and after STOP2, the FSM SHALL go to IDLE.
REQ-024 A stop sample of 0 SHALL pulse `io_frame_err` for one cycle, discard the frame, and return to IDLE.
REQ-025 On the final valid stop sample, the frame SHALL be written to the FIFO at that clock edge, so `io_deq_valid` is visible the next cycle; a pending parity error SHALL pulse `io_parity_err` in the same cycle, and the data SHALL still be written.
REQ-026 A write attempted while the FIFO is full and there is no pop in the same cycle SHALL drop the byte and pulse `io_overrun`; a full FIFO with a simultaneous pop SHALL accept the write.
REQ-027 A pop SHALL occur when `io_deq_valid` && `io_deq_ready`; a simultaneous push and pop SHALL leave `io_count` unchanged.
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH, and the entry order SHALL be strict FIFO.
REQ-029 `io_en`=0 SHALL force the FSM to IDLE within one cycle, discard any partial frame, and retain the FIFO contents and pop capability.
REQ-030 `io_div`, `io_parity` and `io_stop2` SHALL be sampled at the START-to-DATA transition and held for the rest of the frame.

Reset
REQ-031 Reset SHALL put the FSM in IDLE and clear the pointers, `io_count`, the counter and the shift register, and set the synchronizer flops to 1.
REQ-032 Reset SHALL drive `io_deq_valid`, `io_count` and all error pulses to 0; `io_deq_bits` SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame and flush the FIFO, with no error pulse.

Configuration
REQ-034 With macro UART_RX_PARITY_EN defined, parity SHALL be handled as in REQ-008 and REQ-022.
REQ-035 Without UART_RX_PARITY_EN: no PARITY state; `io_parity` SHALL be ignored, no parity bit is expected, and `io_parity_err` SHALL be tied to 0.

Verification
REQ-036 `io_div`=15, no parity, 1 stop bit, frame 0xA5 -> `io_deq_bits`=0xA5 and `io_count`=1 one clock after the stop sample, with no error pulse.
REQ-037 Even parity, frame 0x3C sent with parity bit 1 -> `io_parity_err` pulses for 1 cycle and 0x3C is present in the FIFO (requires UART_RX_PARITY_EN).
REQ-038 Frame 0x55 with the stop bit held low -> `io_frame_err` pulses for 1 cycle and `io_count` stays 0.
REQ-039 FIFO_DEPTH=4, frames 0x01..0x05 sent with `io_deq_ready`=0 -> `io_overrun` pulses on the 5th frame; popping afterwards yields 0x01..0x04, then `io_deq_valid`=0.
REQ-040 `io_rxd` low for 4 clocks only (`io_div`=15) -> false start, FSM back in IDLE, and no push or flag.
REQ-041 `reset` asserted in the middle of the DATA state of frame 0x81 with 2 entries queued -> `io_count`=0 and no flags; a following frame 0x7E is received correctly.
